// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sequencer.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of a counter holding 0..hold_cycles-1, never narrower than one bit.
  function automatic int hold_w(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tts_hold_timer.sv
// Loadable down-counter: after a load, expire pulses on the HOLD_CYCLES-th
// enabled cycle, marking the last cycle a stimulus vector is held.
module tts_hold_timer
  import tts_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int HW = hold_w(HOLD_CYCLES);
  localparam logic [HW-1:0] LOAD_VAL = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] cnt;

  // Reload on a new vector, otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - HW'(1);
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps every input vector of a small combinational
// block, samples its output after a hold interval and compares it with the
// expected table, reporting mismatch count, first failing index and pass.
// Optional build macro TTS_STOP_ON_FAIL_EN: end the run at the first mismatch.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int                  N_IN        = 3,
  parameter int                  HOLD_CYCLES = 1,
  parameter logic [2**N_IN-1:0]  EXPECT      = 8'hE8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_o,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_idx
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_t state, state_next;
  logic   timer_load;
  logic   expire;
  logic   accept;
  logic   mismatch;
  logic   last_vec;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign mismatch = (state == SAMPLE) && (dut_o != EXPECT[stim]);
  assign last_vec = (stim == LAST_VEC);

  tts_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (state == DRIVE),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the hold timer is reloaded on every entry into DRIVE.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = DRIVE;
          timer_load = 1'b1;
        end
      end
      DRIVE: begin
        if (expire) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
`ifdef TTS_STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
`else
        if (last_vec) begin
`endif
          state_next = DONE;
        end else begin
          state_next = DRIVE;
          timer_load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stimulus vector and result counters; a start while busy never reaches here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim     <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
    end else if (accept) begin
      stim     <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
    end else if (state == SAMPLE) begin
      if (mismatch) begin
        err_cnt <= err_cnt + (N_IN+1)'(1);
        if (err_cnt == '0) begin
          fail_idx <= stim;
        end
      end
      if (state_next == DRIVE) begin
        stim <= stim + N_IN'(1);
      end
    end
  end

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == '0);

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Self-checking sequencer for a small combinational logic block under test (N_IN inputs, one output). On a start request it walks the inputs through every binary combination in ascending order, holds each for a settle interval and samples the block's output. It compares each sample against a parameterised expected truth table, then reports a mismatch count, the first failing index and pass/fail. It sits beside the combinational unit on the lab board or in simulation and replaces hand-written stimulus sequences.

## Interface
- N_IN, 3: number of inputs to the block under test (1–6).
- HOLD_CYCLES, 1: cycles each input vector is driven before sampling (≥1).
- EXPECT, 8'hE8: expected output table, width 2**N_IN; bit k is the required output for input vector k.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a run; accepted only in IDLE or DONE.
- dut_o  in  1  output of the block under test.
- stim  out  N_IN  input vector driven to the block; stim[0] = I0.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  high in DONE; held until next accepted start or rst.
- pass  out  1  done && err_cnt == 0.
- err_cnt  out  N_IN+1  number of mismatching vectors in the current/last run.
- fail_idx  out  N_IN  index of first mismatch; valid when err_cnt != 0, else 0.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: stim=0, outputs quiet. start=1 → DRIVE; clear err_cnt, fail_idx, hold counter; stim=0.
- DRIVE: stim stable; hold counter counts 0..HOLD_CYCLES-1; at last count → SAMPLE.
- SAMPLE: compare dut_o with EXPECT[stim]. On mismatch: err_cnt+1; if err_cnt was 0, fail_idx←stim. If stim == 2**N_IN-1 → DONE, else stim+1, → DRIVE.
- DONE: stim holds last vector; done=1; start=1 → restart exactly as from IDLE.
- start while busy: ignored, no effect on any register.
- err_cnt width N_IN+1 holds the full 2**N_IN count; no saturation needed. stim increment never wraps inside a run.
- rst at any time: state=IDLE, stim=0, err_cnt=0, fail_idx=0, busy=0, done=0, pass=0.

## Timing
- Reset values: all outputs 0.
- start sampled at cycle t → busy=1, stim=0 from t+1.
- Each vector occupies HOLD_CYCLES+1 cycles (HOLD_CYCLES DRIVE + 1 SAMPLE).
- done rises 2**N_IN·(HOLD_CYCLES+1) cycles after the accepting edge; busy falls on the same edge.
- dut_o is sampled on the clock edge ending SAMPLE; it only needs to settle within HOLD_CYCLES+1 cycles of a stim change.
- err_cnt/fail_idx update one cycle after the SAMPLE edge and are registered outputs.

## Configuration
- TTS_STOP_ON_FAIL_EN defined: first mismatch in SAMPLE goes straight to DONE. err_cnt=1, fail_idx=failing vector, stim holds it. Remaining vectors are skipped.
- Undefined: the full table is always swept and every mismatch is counted.

## Structure
- Package tts_pkg: state enum (IDLE, DRIVE, SAMPLE, DONE) and a width helper for the hold counter (clog2 of HOLD_CYCLES).
- One sub-module, tts_hold_timer: loadable down-counter that pulses `expire` after HOLD_CYCLES cycles. The FSM, compare and counters stay in the top module.

## Test plan
- Majority-function model, EXPECT=8'hE8, HOLD_CYCLES=1, start pulse → stim steps 0..7 every 2 cycles; done 16 cycles after accept; err_cnt=0; pass=1.
- dut_o stuck at 0, same params → err_cnt=4, fail_idx=3, pass=0.
- start pulsed at cycle 5 of a run → no restart; done still at cycle 16; counts unchanged.
- rst asserted mid-run with stim=4 → all outputs 0 immediately (asynchronous); a new start gives a full clean run.
- With TTS_STOP_ON_FAIL_EN and dut_o stuck at 0 → done after 8 cycles (4 vectors × 2); err_cnt=1; fail_idx=3; stim=3.
- start in DONE after a failing run, correct model → err_cnt cleared; second run passes.
